// File: rtl/data_ram.sv
// data_ram: byte-addressable word RAM with combinational loads and sticky misalignment capture.
// Define DATA_RAM_MMIO_EN to add a 16-byte MMIO window with mtime, console TX and TX drop counter.
module data_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        W_en,
  input  logic        R_en,
  input  logic [2:0]  RW_type,
  input  logic [31:0] ram_addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        misalign_err,
  output logic [31:0] misalign_addr,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  size_e         size;
  logic          is_unsigned;
  logic          misaligned;
  logic          in_window;
  logic          ram_we;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   ram_load;
  logic [31:0]   mmio_load;
  logic [31:0]   wr_data;
  logic [3:0]    wr_mask;
  logic [31:0]   mem [DEPTH_WORDS];

  // Undefined func3 codes (011, 110, 111) fall through to word accesses.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    size        = SZ_WORD;
    is_unsigned = RW_type[2];
    case (RW_type)
      3'b000, 3'b100: size = SZ_BYTE;
      3'b001, 3'b101: size = SZ_HALF;
      default:        size = SZ_WORD;
    endcase
  end

  assign misaligned = (W_en || R_en) &&
                      (((size == SZ_HALF) && ram_addr[0]) ||
                       ((size == SZ_WORD) && (ram_addr[1:0] != 2'b00)));

  assign word_idx = ram_addr[AW+1:2];
  assign rd_word  = mem[word_idx];
  assign rd_byte  = rd_word[{ram_addr[1:0], 3'b000} +: 8];
  assign rd_half  = rd_word[{ram_addr[1], 4'b0000} +: 16];

  always_comb begin
    ram_load = rd_word;
    case (size)
      SZ_BYTE: ram_load = is_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      SZ_HALF: ram_load = is_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: ram_load = rd_word;
    endcase
  end

  // Reading the array before the edge gives pre-write data on same-cycle read/write.
  always_comb begin
    load_data = 32'h0;
    if (R_en && !misaligned)
      load_data = in_window ? mmio_load : ram_load;
  end

  // Lane replication lets one mask select which bytes of the word are written.
  always_comb begin
    wr_data = store_data;
    wr_mask = 4'b1111;
    case (size)
      SZ_BYTE: begin
        wr_data = {4{store_data[7:0]}};
        wr_mask = 4'b0001 << ram_addr[1:0];
      end
      SZ_HALF: begin
        wr_data = {2{store_data[15:0]}};
        wr_mask = ram_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wr_data = store_data;
        wr_mask = 4'b1111;
      end
    endcase
  end

  assign ram_we = W_en && !misaligned && !in_window;

  // NOTE: the array has no reset so contents survive rst_n and map onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) mem[word_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      misalign_err  <= 1'b0;
      misalign_addr <= 32'h0;
    end else if (misaligned && !misalign_err) begin
      misalign_err  <= 1'b1;
      misalign_addr <= ram_addr;
    end
  end

`ifdef DATA_RAM_MMIO_EN
  logic [63:0] mtime;
  logic [31:0] tx_drop;
  logic        tx_wr;

  assign in_window = (ram_addr[31:4] == MMIO_BASE[31:4]);
  assign tx_wr     = W_en && in_window && !misaligned && (ram_addr[3:2] == 2'd2);

  // Window reads ignore access size and always return the full register.
  always_comb begin
    mmio_load = 32'h0;
    case (ram_addr[3:2])
      2'd0: mmio_load = mtime[31:0];
      2'd1: mmio_load = mtime[63:32];
      2'd2: mmio_load = {31'h0, tx_valid};
      2'd3: mmio_load = tx_drop;
      default: mmio_load = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime    <= 64'h0;
      tx_drop  <= 32'h0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h0;
    end else begin
      mtime <= mtime + 64'd1;
      if (tx_wr && tx_valid && !tx_ready) begin
        if (tx_drop != 32'hFFFF_FFFF) tx_drop <= tx_drop + 32'd1;
      end else if (tx_wr) begin
        // Also covers a write on the handshake edge: the new byte replaces the one leaving.
        tx_data  <= store_data[7:0];
        tx_valid <= 1'b1;
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end
`else
  logic unused_mmio;

  assign in_window   = 1'b0;
  assign mmio_load   = 32'h0;
  assign tx_valid    = 1'b0;
  assign tx_data     = 8'h0;
  assign unused_mmio = ^{tx_ready, ram_addr[31:AW+2], MMIO_BASE};
`endif

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: randomized scoreboard bench for data_ram against a byte-array reference model.
// Load expectations are queued by the driver and popped by a negedge monitor.
module tb_data_ram;

  localparam int          DEPTH = 64;
  localparam int          BYTES = DEPTH * 4;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        W_en = 1'b0;
  logic        R_en = 1'b0;
  logic [2:0]  RW_type = 3'b010;
  logic [31:0] ram_addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        tx_ready = 1'b0;
  logic [31:0] load_data;
  logic        misalign_err;
  logic [31:0] misalign_addr;
  logic        tx_valid;
  logic [7:0]  tx_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  ref_mem [BYTES];
  logic        ref_err;
  logic [31:0] ref_maddr;

  data_ram #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .W_en(W_en), .R_en(R_en), .RW_type(RW_type),
    .ram_addr(ram_addr), .store_data(store_data), .load_data(load_data),
    .misalign_err(misalign_err), .misalign_addr(misalign_addr),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: RAM as a flat byte array indexed modulo its size.
  function automatic int size_of(input logic [2:0] t);
    case (t)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit is_mis(input logic [2:0] t, input logic [31:0] a);
    return (a % 32'(size_of(t))) != 32'h0;
  endfunction

  function automatic int byte_ix(input logic [31:0] a, input int i);
    return int'((a + 32'(i)) % 32'(BYTES));
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] a);
    int          n = size_of(t);
    logic [31:0] v = 32'h0;
    if (is_mis(t, a)) return 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[byte_ix(a, i)]) << (8 * i));
    if (!t[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    if (is_mis(t, a)) return;
    for (int i = 0; i < size_of(t); i++) ref_mem[byte_ix(a, i)] = d[8*i +: 8];
  endtask

  // One access cycle, entered and left at posedge+1. use_exp overrides the model value.
  task automatic cycle(input bit w, input bit r, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] d, input string nm,
                       input bit use_exp = 1'b0, input logic [31:0] exp = 32'h0);
    exp_t e;
    W_en = w; R_en = r; RW_type = t; ram_addr = a; store_data = d;
    if (r) begin
      e.name = nm;
      e.val  = use_exp ? exp : ref_load(t, a);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (w) ref_store(t, a, d);
    if (rst_n && (w || r) && is_mis(t, a) && !ref_err) begin
      ref_err   = 1'b1;
      ref_maddr = a;
    end
    W_en = 1'b0; R_en = 1'b0;
  endtask

  task automatic check_misalign(input string nm);
    check({nm, "_err"}, {31'h0, misalign_err}, {31'h0, ref_err});
    check({nm, "_addr"}, misalign_addr, ref_maddr);
  endtask

  // Monitor: load_data is combinational, so compare mid-cycle whenever a load is presented.
  always @(negedge clk) begin
    if (R_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: load %h with no expectation queued", load_data);
      end else begin
        mon_e = exp_q.pop_front();
        check(mon_e.name, load_data, mon_e.val);
      end
    end else begin
      check("load_idle_zero", load_data, 32'h0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, d, w8;
    logic [2:0]  t;
    bit          w, r;

    ref_err = 1'b0;
    ref_maddr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_misalign_err", {31'h0, misalign_err}, 32'h0);
    check("rst_misalign_addr", misalign_addr, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);

    // Release reset in the same cycle as the first store; that store must land.
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 3'b010, 32'(i * 4), $urandom, "");
    cycle(0, 1, 3'b010, 32'h0, 32'h0, "release_cycle_store");

    cycle(1, 0, 3'b010, 32'h10, 32'h8000_00F1, "");
    cycle(0, 1, 3'b000, 32'h10, 32'h0, "lb_sign", 1'b1, 32'hFFFF_FFF1);
    cycle(0, 1, 3'b100, 32'h13, 32'h0, "lbu_zero", 1'b1, 32'h0000_0080);
    cycle(0, 1, 3'b001, 32'h12, 32'h0, "lh_sign", 1'b1, 32'hFFFF_8000);

    cycle(1, 0, 3'b010, 32'h10, 32'h1122_3344, "");
    cycle(1, 0, 3'b000, 32'h11, 32'h0000_00AB, "");
    cycle(0, 1, 3'b010, 32'h10, 32'h0, "sb_lane_merge", 1'b1, 32'h1122_AB44);
    cycle(1, 0, 3'b101, 32'h12, 32'hFFFF_BEEF, "");
    cycle(0, 1, 3'b101, 32'h12, 32'h0, "lhu_zero", 1'b1, 32'h0000_BEEF);

    // Same-word read and write in one cycle returns the old word.
    cycle(1, 1, 3'b010, 32'h10, 32'hCAFE_F00D, "rw_same_cycle_old", 1'b1, 32'hBEEF_AB44);
    cycle(0, 1, 3'b011, 32'h10, 32'h0, "type011_as_word", 1'b1, 32'hCAFE_F00D);

    check_misalign("pre_misalign");
    w8 = ref_load(3'b010, 32'h8);
    cycle(0, 1, 3'b010, 32'h6, 32'h0, "lw_misaligned_zero", 1'b1, 32'h0);
    check("first_misalign_err", {31'h0, misalign_err}, 32'h1);
    check("first_misalign_addr", misalign_addr, 32'h6);
    cycle(1, 0, 3'b010, 32'h9, 32'hDEAD_BEEF, "");
    cycle(1, 1, 3'b001, 32'h9, 32'h1234_5678, "lh_misaligned_zero", 1'b1, 32'h0);
    check("sticky_misalign_addr", misalign_addr, 32'h6);
    cycle(0, 1, 3'b010, 32'h8, 32'h0, "misaligned_store_suppressed", 1'b1, w8);

    // Upper address bits above the index are ignored.
    cycle(1, 0, 3'b010, 32'h1234_5000 | 32'(BYTES + 8'h24), 32'h5A5A_0001, "");
    cycle(0, 1, 3'b010, 32'h24, 32'h0, "alias_upper_bits", 1'b1, 32'h5A5A_0001);

`ifndef DATA_RAM_MMIO_EN
    // Without the window its addresses are ordinary aliased RAM and TX stays idle.
    tx_ready = 1'b0;
    cycle(1, 0, 3'b010, BASE + 32'h8, 32'h0000_0041, "");
    cycle(0, 1, 3'b010, 32'h8, 32'h0, "window_aliases_ram", 1'b1, 32'h0000_0041);
    check("tx_valid_tied", {31'h0, tx_valid}, 32'h0);
    check("tx_data_tied", {24'h0, tx_data}, 32'h0);
`endif

    for (int i = 0; i < 400; i++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      t = 3'($urandom_range(0, 7));
      a = $urandom;
      d = $urandom;
`ifdef DATA_RAM_MMIO_EN
      if (a[31:4] == BASE[31:4]) a[31] = 1'b0;
`endif
      cycle(w, r, t, a, d, "rand_load");
      if (i % 50 == 0) check_misalign("rand_misalign");
    end

    // Mid-cycle reset clears flags without waiting for an edge; RAM is kept.
    rst_n = 1'b0;
    #1;
    check("midrst_misalign_err", {31'h0, misalign_err}, 32'h0);
    check("midrst_misalign_addr", misalign_addr, 32'h0);
    check("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("midrst_tx_data", {24'h0, tx_data}, 32'h0);
    ref_err = 1'b0;
    ref_maddr = 32'h0;
    cycle(0, 1, 3'b100, 32'h13, 32'h0, "load_during_reset");
    cycle(0, 1, 3'b010, 32'h7, 32'h0, "misaligned_in_reset", 1'b1, 32'h0);
    check_misalign("reset_ignores_misalign");
    rst_n = 1'b1;

`ifdef DATA_RAM_MMIO_EN
    repeat (10) @(posedge clk);
    #1;
    cycle(0, 1, 3'b010, BASE, 32'h0, "mtime_after_10", 1'b1, 32'd10);

    tx_ready = 1'b0;
    cycle(1, 0, 3'b010, BASE + 32'h8, 32'h0000_0041, "");
    check("tx_valid_set", {31'h0, tx_valid}, 32'h1);
    check("tx_data_first", {24'h0, tx_data}, 32'h41);
    cycle(1, 0, 3'b010, BASE + 32'h8, 32'h0000_0042, "");
    check("tx_data_kept_on_drop", {24'h0, tx_data}, 32'h41);
    cycle(0, 1, 3'b000, BASE + 32'hC, 32'h0, "tx_drop_count", 1'b1, 32'h1);
    cycle(0, 1, 3'b010, BASE + 32'h8, 32'h0, "tx_status_read", 1'b1, 32'h1);
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    check("tx_valid_cleared", {31'h0, tx_valid}, 32'h0);
    cycle(1, 0, 3'b010, BASE + 32'h8, 32'h0000_0050, "");
    tx_ready = 1'b1;
    cycle(1, 0, 3'b010, BASE + 32'h8, 32'h0000_0051, "");
    tx_ready = 1'b0;
    check("tx_accept_on_handshake_valid", {31'h0, tx_valid}, 32'h1);
    check("tx_accept_on_handshake_data", {24'h0, tx_data}, 32'h51);
    cycle(0, 1, 3'b010, BASE + 32'hC, 32'h0, "tx_drop_unchanged", 1'b1, 32'h1);

    force dut.mtime = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.mtime;
    @(posedge clk);
    #1;
    cycle(0, 1, 3'b010, BASE, 32'h0, "mtime_lo_wrap", 1'b1, 32'h0);
    cycle(0, 1, 3'b010, BASE + 32'h4, 32'h0, "mtime_hi_carry", 1'b1, 32'h1);
`endif

    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 3'b010, 32'(i * 4), 32'h0, "ram_kept_over_reset");
    cycle(0, 1, 3'b001, 32'h21, 32'h0, "misaligned_after_reset", 1'b1, 32'h0);
    check("recapture_err", {31'h0, misalign_err}, 32'h1);
    check("recapture_addr", misalign_addr, 32'h21);
    check_misalign("final_misalign");

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
